// File: rtl/fifo_rr_sched.sv
// Purpose : round-robin read scheduler sharing one output port between NUM_FIFO sync FIFOs.
// Latency : pop one cycle after a request is seen, o_valid two cycles after the pop edge.
// Backpres: o_data/o_src are held while o_ready is low; no pop is issued until the handshake.
//
// Ports:
//   clk, rst_n   - single clock, synchronous active-low reset
//   fifo_empty   - per-FIFO empty flags (bit i = FIFO i)
//   fifo_data    - per-FIFO registered read data, FIFO i at [i*FIFO_WIDTH +: FIFO_WIDTH]
//   fifo_pop     - registered one-hot (or zero) pop strobe to the FIFOs
//   o_data/o_src - captured word and the index of the FIFO it came from
//   o_valid      - o_data/o_src valid; o_ready accepts them
//
// Optional feature: define FIFO_ARB_BURST_EN to let a grant carry up to
// BURST_LEN consecutive words from the same FIFO.

module fifo_rr_sched #(
  parameter int NUM_FIFO   = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int SRC_W      = $clog2(NUM_FIFO),
  parameter int BURST_LEN  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_FIFO-1:0]            fifo_empty,
  input  logic [NUM_FIFO*FIFO_WIDTH-1:0] fifo_data,
  output logic [NUM_FIFO-1:0]            fifo_pop,
  output logic [FIFO_WIDTH-1:0]          o_data,
  output logic [SRC_W-1:0]               o_src,
  output logic                           o_valid,
  input  logic                           o_ready
);

  typedef enum logic [1:0] {IDLE, POP, LATCH, SEND} state_t;

  state_t                state, state_nxt;
  logic [SRC_W-1:0]      grant, grant_nxt;
  logic [SRC_W-1:0]      last, last_nxt;
  logic [NUM_FIFO-1:0]   pop_nxt;
  logic [FIFO_WIDTH-1:0] data_nxt;
  logic [SRC_W-1:0]      src_nxt;
  logic                  valid_nxt;

  logic                  any_req;
  logic [SRC_W-1:0]      req_idx;
  logic [FIFO_WIDTH-1:0] sel_data;
  int                    cand;
  logic [SRC_W-1:0]      cand_idx;

`ifdef FIFO_ARB_BURST_EN
  logic [3:0] burst_cnt, burst_cnt_nxt;
`endif

  // Round-robin search: first non-empty FIFO starting at last+1, wrapping
  // modulo NUM_FIFO (also correct for non-power-of-2 counts).
  always_comb begin
    any_req  = 1'b0;
    req_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_FIFO; k++) begin
      cand = int'(last) + k;
      if (cand >= NUM_FIFO) cand = cand - NUM_FIFO;
      cand_idx = SRC_W'(cand);
      if (!any_req && !fifo_empty[cand_idx]) begin
        any_req = 1'b1;
        req_idx = cand_idx;
      end
    end
  end

  // Read-data mux for the granted FIFO.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_FIFO; i++) begin
      if (grant == SRC_W'(i)) sel_data = fifo_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    pop_nxt   = '0;
    data_nxt  = o_data;
    src_nxt   = o_src;
    valid_nxt = o_valid;
`ifdef FIFO_ARB_BURST_EN
    burst_cnt_nxt = burst_cnt;
`endif
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_nxt = req_idx;
          last_nxt  = req_idx;
          pop_nxt   = NUM_FIFO'(1) << req_idx;
          state_nxt = POP;
`ifdef FIFO_ARB_BURST_EN
          burst_cnt_nxt = '0;
`endif
        end
      end
      // Empty flags are ignored here and in LATCH: the FIFO updates its
      // flag only one cycle after the pop.
      POP: state_nxt = LATCH;
      LATCH: begin
        data_nxt  = sel_data;
        src_nxt   = grant;
        valid_nxt = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        // o_valid is always set in SEND, so o_ready alone completes the handshake.
        if (o_ready) begin
          valid_nxt = 1'b0;
`ifdef FIFO_ARB_BURST_EN
          if (!fifo_empty[grant] && (burst_cnt < 4'(BURST_LEN - 1))) begin
            burst_cnt_nxt = burst_cnt + 4'd1;
            pop_nxt       = NUM_FIFO'(1) << grant;
            state_nxt     = POP;
          end else begin
            burst_cnt_nxt = '0;
            state_nxt     = IDLE;
          end
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      last     <= SRC_W'(NUM_FIFO - 1);   // FIFO 0 gets first priority
      fifo_pop <= '0;
      o_data   <= '0;
      o_src    <= '0;
      o_valid  <= 1'b0;
`ifdef FIFO_ARB_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      last     <= last_nxt;
      fifo_pop <= pop_nxt;
      o_data   <= data_nxt;
      o_src    <= src_nxt;
      o_valid  <= valid_nxt;
`ifdef FIFO_ARB_BURST_EN
      burst_cnt <= burst_cnt_nxt;
`endif
    end
  end

endmodule

// File: doc/fifo_rr_sched.md
# fifo_rr_sched

Round-robin read scheduler that shares one downstream output port between `NUM_FIFO` upstream synchronous FIFOs. It watches each FIFO's empty flag, issues single-cycle pops to the granted FIFO, and captures that FIFO's registered read data. It presents the word downstream with a valid/ready handshake. It is the only popper of the FIFOs it serves and replaces the ad-hoc FIFO-to-MUX read logic in the datapath.

## Interface

- `NUM_FIFO`, default 4: number of upstream FIFOs; legal range 2..16.
- `FIFO_WIDTH`, default 16: data word width; matches the FIFO width.
- `SRC_W`, default `$clog2(NUM_FIFO)`: width of the source index.
- `BURST_LEN`, default 4: maximum consecutive words per grant; used only with `FIFO_ARB_BURST_EN`; legal range 1..15.

Ports:

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `fifo_empty` in `NUM_FIFO`: per-FIFO `is_fifo_empty`; bit i belongs to FIFO i.
- `fifo_data` in `NUM_FIFO*FIFO_WIDTH`: per-FIFO `out_fifo`; FIFO i occupies `[i*FIFO_WIDTH +: FIFO_WIDTH]`.
- `fifo_pop` out `NUM_FIFO`: registered, one-hot or zero; drives each FIFO's `i_pop`.
- `o_data` out `FIFO_WIDTH`: captured word.
- `o_src` out `SRC_W`: index of the FIFO `o_data` came from.
- `o_valid` out 1: `o_data` and `o_src` are valid.
- `o_ready` in 1: downstream accepts the word.

## Operation

- FSM states:
  - `IDLE`: waiting for a non-empty FIFO.
  - `POP`: `fifo_pop` is asserted for exactly one cycle.
  - `LATCH`: `fifo_data` of the granted FIFO is valid.
  - `SEND`: word is held until the handshake completes.
- **IDLE**: if any `fifo_empty` bit is 0, grant the first non-empty FIFO, searching from `(last+1) mod NUM_FIFO` upward with wrap. Then:
  - `grant <= idx`, `last <= idx`.
  - `fifo_pop <= onehot(idx)`.
  - go to `POP`.
  - If all FIFOs are empty, stay in `IDLE`.
- **POP**: `fifo_pop <= 0`, go to `LATCH`.
- **LATCH**: `o_data <= fifo_data[grant]`, `o_src <= grant`, `o_valid <= 1`, go to `SEND`.
- **SEND**: while `o_ready` = 0, hold `o_valid`, `o_data` and `o_src` stable. On `o_valid & o_ready`, set `o_valid <= 0` and go to `IDLE` (see Configuration for burst mode).
- Arithmetic: the search pointer wraps modulo `NUM_FIFO`. This applies to non-power-of-2 values as well: index `NUM_FIFO-1` is followed by 0.
- `fifo_empty` is sampled only in `IDLE`, plus `SEND` in burst mode. Flags are ignored in `POP` and `LATCH`, because the FIFO updates its flag one cycle after a pop.
- Reset (any state): go to `IDLE` with:
  - `fifo_pop = 0`, `o_valid = 0`, `o_data = 0`, `o_src = 0`.
  - `last = NUM_FIFO-1`, so FIFO 0 has first priority.
  - burst count = 0.
  - A word that was popped but not yet accepted is discarded. Upstream FIFOs share `rst_n`.

## Timing

- Request detected at edge k (`IDLE`, some `fifo_empty` = 0):
  - `fifo_pop` high during cycle k..k+1.
  - The FIFO registers its data at edge k+1.
  - `o_valid` rises after edge k+2.
- Handshake at edge m returns the FSM to `IDLE`. The earliest next pop is at edge m+1.
- Sustained throughput with `o_ready` = 1: 1 word per 4 cycles without burst, 1 word per 3 cycles within a burst.
- `fifo_pop` is never asserted for more than one consecutive cycle per word, and never to more than one FIFO.
- `o_ready` may be high before `o_valid`; this has no effect outside `SEND`.

## Configuration

- Macro: `FIFO_ARB_BURST_EN`.
- Defined: on a handshake in `SEND`, if `fifo_empty[grant]` = 0 and `burst_cnt < BURST_LEN-1`:
  - `burst_cnt++`, `fifo_pop <= onehot(grant)`, `o_valid <= 0`.
  - go directly to `POP`; `last` is unchanged.
  - Otherwise, clear `burst_cnt` and go to `IDLE`.
  - `burst_cnt` is cleared on every new grant from `IDLE`.
- Undefined: `burst_cnt` and `BURST_LEN` logic is absent. Every handshake returns to `IDLE`, so each grant carries exactly one word.

## Test plan

- **Reset:** hold `rst_n` = 0 for 3 cycles, all FIFOs non-empty -> `fifo_pop` = 0 and `o_valid` = 0. First grant after release is FIFO 0, and `o_src` = 0.
- **Single word:** FIFO 2 holds 0xA5A5, others empty, `o_ready` = 1 -> one pop pulse to bit 2. `o_valid` rises 2 cycles after the pop edge with `o_data` = 0xA5A5, `o_src` = 2, then `IDLE`.
- **Round-robin order:** all 4 FIFOs hold 2 words each, burst off -> `o_src` sequence 0,1,2,3,0,1,2,3 at 1 word per 4 cycles.
- **Backpressure:** `o_ready` = 0 for 10 cycles during `SEND` -> `o_data`/`o_src` are stable and no further pops occur. Accept on the 11th cycle, then the next grant proceeds.
- **Burst:** with `FIFO_ARB_BURST_EN`, `BURST_LEN` = 4, FIFO 1 holding 6 words and FIFO 3 holding 1 word -> `o_src` sequence 1,1,1,1,3,1,1 with 3-cycle spacing inside each burst.
- **Reset mid-operation:** assert `rst_n` = 0 in `LATCH` -> `o_valid` stays 0 and the next grant starts from FIFO 0.
